// File: rtl/mitll_not_seq_if.sv
// Request/grant and SFQ NOT-cell toggle lines shared between the test logic and the sequencer.
// Latency: none, this is a plain signal bundle.
// Backpressure: none; requesters hold req until done, and the cell lines are free-running toggles.
//
// Ports (signal bundle):
//   req/din      requester levels and operands (driven by master)
//   gnt/done     one-hot single-cycle pulses back to the requesters
//   dout         result, held between done pulses
//   gate_in/clk  toggle lines to the cell (driven by the sequencer)
//   gate_out     toggle line from the cell (driven by master/cell side)
//   err/fault    sticky status flags
interface mitll_not_seq_if;
    logic [1:0] req;
    logic [1:0] din;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       dout;
    logic       gate_in;
    logic       gate_clk;
    logic       gate_out;
    logic       err;
    logic       fault;

    modport master (
        output req, din, gate_out,
        input  gnt, done, dout, gate_in, gate_clk, err, fault
    );

    modport slave (
        input  req, din, gate_out,
        output gnt, done, dout, gate_in, gate_clk, err, fault
    );
endinterface

// File: rtl/mitll_not_seq.sv
// Round-robin sequencer sharing one clocked SFQ NOT cell between two requesters.
// Latency: gnt one cycle after grant edge k; done at k_clk+DLY_CYC, where k_clk >= k+SETUP_CYC.
// Backpressure: requests wait in IDLE until the cell's input/clock critical-timing windows have elapsed.
//
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  slave side of mitll_not_seq_if (req/din in, gnt/done/dout out, cell toggle lines, err/fault)
module mitll_not_seq #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned DLY_CYC    = 10,
    parameter int unsigned CT_IN_CYC  = 2,
    parameter int unsigned CT_CLK_CYC = 8
) (
    input  logic           clk,
    input  logic           rst,
    mitll_not_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT_OUT} state_t;

    localparam logic [7:0] SETUP_INIT = 8'(SETUP_CYC - 1);
    localparam logic [7:0] DLY_INIT   = 8'(DLY_CYC - 1);
    localparam logic [7:0] CT_IN_8    = 8'(CT_IN_CYC);
    localparam logic [7:0] CT_CLK_8   = 8'(CT_CLK_CYC);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] since_q, since_d, since_now;
    logic       lp_q, lp_d;
    logic       g_q, g_d;
    logic       d_q, d_d;
    logic       seen_q, seen_d, seen_now;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic       dout_q, dout_d;
    logic       gin_q, gin_d;
    logic       gclk_q, gclk_d;
    logic       err_q, err_d;
    logic       fault_q, fault_d;
    logic       gout_q;
    logic       out_edge;
    logic       sel;

    // since_q holds the count as of the last edge; since_now is the number of
    // cycles elapsed at the edge being evaluated, so a pulse at edge p makes
    // since_now == m at edge p+m and the windows land exactly on p+CT_*.
    assign since_now = (since_q == 8'hFF) ? 8'hFF : since_q + 8'd1;
    assign out_edge  = bus.gate_out != gout_q;
    assign seen_now  = seen_q | out_edge;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        since_d = since_now;
        lp_d    = lp_q;
        g_d     = g_q;
        d_d     = d_q;
        seen_d  = seen_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        dout_d  = dout_q;
        gin_d   = gin_q;
        gclk_d  = gclk_q;
        err_d   = err_q;
        fault_d = fault_q;
        sel     = 1'b0;

        case (state_q)
            IDLE: begin
                if (out_edge) err_d = 1'b1;
                if (bus.req != 2'b00 && since_now >= CT_IN_8) begin
                    // Both pending: the one not served last wins.
                    sel     = (bus.req == 2'b11) ? ~lp_q : bus.req[1];
                    g_d     = sel;
                    lp_d    = sel;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    d_d     = bus.din[sel];
                    if (bus.din[sel]) gin_d = ~gin_q;
                    cnt_d   = SETUP_INIT;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (out_edge) err_d = 1'b1;
                if (cnt_q == 8'd0 && since_now >= CT_CLK_8) begin
                    gclk_d  = ~gclk_q;
                    since_d = 8'd0;
                    cnt_d   = DLY_INIT;
                    seen_d  = 1'b0;
                    state_d = WAIT_OUT;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WAIT_OUT: begin
                if (out_edge && seen_q) err_d = 1'b1;
                seen_d = seen_now;
                // An output edge arriving on the closing edge still counts.
                if (cnt_q == 8'd0) begin
                    dout_d  = seen_now;
                    done_d  = g_q ? 2'b10 : 2'b01;
                    if (seen_now == d_q) fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            since_q <= 8'hFF;
            lp_q    <= 1'b1;
            g_q     <= 1'b0;
            d_q     <= 1'b0;
            seen_q  <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            dout_q  <= 1'b0;
            gin_q   <= 1'b0;
            gclk_q  <= 1'b0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
            // Track the cell's current level so reset never fakes an edge.
            gout_q  <= bus.gate_out;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            since_q <= since_d;
            lp_q    <= lp_d;
            g_q     <= g_d;
            d_q     <= d_d;
            seen_q  <= seen_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            gin_q   <= gin_d;
            gclk_q  <= gclk_d;
            err_q   <= err_d;
            fault_q <= fault_d;
            gout_q  <= bus.gate_out;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.dout     = dout_q;
    assign bus.gate_in  = gin_q;
    assign bus.gate_clk = gclk_q;
    assign bus.err      = err_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_mitll_not_seq.sv
// Self-checking bench for mitll_not_seq: table of single operations plus directed multi-cycle sequences.
// Latency: expectations are hand-computed edge offsets from the grant edge.
// Backpressure: requests are held until done, then dropped in the done cycle.
module tb_mitll_not_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    mitll_not_seq_if bus_if();
    mitll_not_seq_if b3();

    mitll_not_seq dut (.clk(clk), .rst(rst), .bus(bus_if.slave));
    mitll_not_seq #(.DLY_CYC(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] req;
        logic [1:0] din;
        int         nedge;
        logic [1:0] gnt;
        logic       gin;
        logic       dout;
        logic       err;
        logic       fault;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One operation on the default DUT, starting at a negedge. The cell model
    // toggles gate_out 9 cycles after gate_clk (nedge>=1) and additionally
    // 6 cycles after it (nedge>=2).
    task automatic run_op(input logic [1:0] r, input logic [1:0] di, input int nedge,
                          output logic [1:0] g, output logic gin_t, output int dt_gnt,
                          output int dt_clk, output int dt_done, output logic [1:0] dn,
                          output logic dv, output logic got);
        int   t0, tg, tc;
        logic gin0, gclk0;
        t0 = cyc; tg = -1; tc = -1;
        gin0 = bus_if.gate_in; gclk0 = bus_if.gate_clk;
        g = 2'b00; gin_t = 1'b0; dn = 2'b00; dv = 1'b0; got = 1'b0;
        bus_if.req = r; bus_if.din = di;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (tg < 0 && bus_if.gnt != 2'b00) begin
                tg = cyc; g = bus_if.gnt; gin_t = (bus_if.gate_in != gin0);
            end
            if (tc < 0 && bus_if.gate_clk != gclk0) tc = cyc;
            if (tc >= 0 && ((nedge >= 1 && cyc - tc == 8) || (nedge >= 2 && cyc - tc == 5)))
                bus_if.gate_out = ~bus_if.gate_out;
            if (bus_if.done != 2'b00) begin
                got = 1'b1; dn = bus_if.done; dv = bus_if.dout; bus_if.req = 2'b00;
            end
        end
        dt_gnt  = tg - t0;
        dt_clk  = tc - tg;
        dt_done = got ? cyc - tg : -1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_gnt"},      32'(bus_if.gnt),      32'd0);
        chk({tag, "_done"},     32'(bus_if.done),     32'd0);
        chk({tag, "_dout"},     32'(bus_if.dout),     32'd0);
        chk({tag, "_gate_in"},  32'(bus_if.gate_in),  32'd0);
        chk({tag, "_gate_clk"}, 32'(bus_if.gate_clk), 32'd0);
        chk({tag, "_err"},      32'(bus_if.err),      32'd0);
        chk({tag, "_fault"},    32'(bus_if.fault),    32'd0);
    endtask

    initial begin
        logic [1:0] g, dn;
        logic       gin_t, dv, got;
        int         dt_gnt, dt_clk, dt_done;
        logic [1:0] cg[4];
        int         ct[4];
        int         n, ndone;
        int         tg3[2], tc3[2];
        int         ng3, nc3;
        logic       gclk3;

        //           req    din    ne gnt    gin   dout  err   fault
        tbl[0] = '{2'b01, 2'b00, 1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{2'b10, 2'b10, 0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{2'b10, 2'b00, 1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{2'b01, 2'b01, 1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{2'b10, 2'b00, 2, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1};

        bus_if.req = 2'b00; bus_if.din = 2'b00; bus_if.gate_out = 1'b0;
        b3.req = 2'b00; b3.din = 2'b00; b3.gate_out = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].req, tbl[i].din, tbl[i].nedge, g, gin_t, dt_gnt, dt_clk, dt_done, dn, dv, got);
            chk($sformatf("row%0d_gnt", i),     32'(g),           32'(tbl[i].gnt));
            chk($sformatf("row%0d_gate_in", i), 32'(gin_t),       32'(tbl[i].gin));
            chk($sformatf("row%0d_gnt_lat", i), 32'(dt_gnt),      32'd1);
            chk($sformatf("row%0d_clk_lat", i), 32'(dt_clk),      32'd1);
            chk($sformatf("row%0d_got", i),     32'(got),         32'd1);
            chk($sformatf("row%0d_done_lat", i),32'(dt_done),     32'd11);
            chk($sformatf("row%0d_done", i),    32'(dn),          32'(tbl[i].gnt));
            chk($sformatf("row%0d_dout", i),    32'(dv),          32'(tbl[i].dout));
            chk($sformatf("row%0d_err", i),     32'(bus_if.err),  32'(tbl[i].err));
            chk($sformatf("row%0d_fault", i),   32'(bus_if.fault),32'(tbl[i].fault));
        end

        // Flags are sticky until reset.
        repeat (20) @(negedge clk);
        chk("sticky_err",   32'(bus_if.err),   32'd1);
        chk("sticky_fault", 32'(bus_if.fault), 32'd1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("clr_err",   32'(bus_if.err),   32'd0);
        chk("clr_fault", 32'(bus_if.fault), 32'd0);

        // Unsolicited output edge while idle.
        @(negedge clk);
        bus_if.gate_out = ~bus_if.gate_out;
        @(negedge clk);
        chk("idle_edge_err",   32'(bus_if.err),   32'd1);
        chk("idle_edge_fault", 32'(bus_if.fault), 32'd0);
        chk("idle_edge_gnt",   32'(bus_if.gnt),   32'd0);

        // Contention: both requesters held for four transactions.
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        @(negedge clk);
        bus_if.din = 2'b00; bus_if.req = 2'b11; n = 0;
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            if (bus_if.gnt != 2'b00) begin
                cg[n] = bus_if.gnt; ct[n] = cyc; n++;
            end
        end
        bus_if.req = 2'b00;
        chk("cont_count", 32'(n), 32'd4);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("cont_gnt%0d", i), 32'(cg[i]), (i % 2 == 1) ? 32'd2 : 32'd1);
            if (i > 0) chk($sformatf("cont_gap%0d", i), 32'(ct[i] - ct[i-1]), 32'd12);
        end
        repeat (15) @(negedge clk);

        // Clock-to-clock window on the short-delay instance.
        gclk3 = b3.gate_clk; ng3 = 0; nc3 = 0; ndone = 0;
        b3.din = 2'b00; b3.req = 2'b01;
        for (int i = 0; i < 40 && nc3 < 2; i++) begin
            @(negedge clk);
            if (b3.gnt != 2'b00 && ng3 < 2) begin tg3[ng3] = cyc; ng3++; end
            if (b3.gate_clk != gclk3) begin
                gclk3 = b3.gate_clk;
                tc3[nc3] = cyc; nc3++;
            end
            if (b3.done != 2'b00) ndone++;
        end
        b3.req = 2'b00;
        chk("ctclk_nclk",  32'(nc3), 32'd2);
        chk("ctclk_ngnt",  32'(ng3), 32'd2);
        chk("ctclk_ndone", 32'(ndone), 32'd1);
        if (nc3 == 2 && ng3 == 2) begin
            chk("ctclk_first_clk", 32'(tc3[0] - tg3[0]), 32'd1);
            chk("ctclk_regrant",   32'(tg3[1] - tg3[0]), 32'd5);
            chk("ctclk_spacing",   32'(tc3[1] - tc3[0]), 32'd8);
            chk("ctclk_second",    32'(tc3[1] - tg3[0]), 32'd9);
        end
        chk("ctclk_err", 32'(b3.err), 32'd0);
        repeat (10) @(negedge clk);

        // Reset in the middle of a transaction (state SETUP).
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        @(negedge clk);
        bus_if.req = 2'b10; bus_if.din = 2'b10; n = 0;
        for (int i = 0; i < 5 && n == 0; i++) begin
            @(negedge clk);
            if (bus_if.gnt != 2'b00) n = 1;
        end
        chk("midrst_granted", 32'(n), 32'd1);
        chk("midrst_gin_pre", 32'(bus_if.gate_in), 32'd1);
        rst = 1'b1;
        #1;
        chk_zero_outputs("midrst");
        bus_if.req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus_if.done != 2'b00) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        run_op(2'b01, 2'b00, 1, g, gin_t, dt_gnt, dt_clk, dt_done, dn, dv, got);
        chk("post_gnt",      32'(g),       32'd1);
        chk("post_gnt_lat",  32'(dt_gnt),  32'd1);
        chk("post_clk_lat",  32'(dt_clk),  32'd1);
        chk("post_done_lat", 32'(dt_done), 32'd11);
        chk("post_dout",     32'(dv),      32'd1);
        chk("post_err",      32'(bus_if.err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mitll_not_seq.md
# mitll_not_seq

Synchronous controller that sequences a clocked SFQ NOT gate cell and shares it between two requesters. It arbitrates requests round-robin and drives the gate's data and clock lines, encoding each pulse as a toggle. It enforces the cell's critical-timing windows in clk cycles, then samples the gate output and returns the inverted result with sticky protocol and logic fault flags. It sits between digital test logic and one behavioural NOT cell.

## Interface
- SETUP_CYC, 1: cycles from gate_in pulse to gate_clk pulse (1..255)
- DLY_CYC, 10: cycles after gate_clk in which an output edge is accepted (1..255)
- CT_IN_CYC, 2: minimum cycles from a gate_clk pulse to the next gate_in pulse (1..255)
- CT_CLK_CYC, 8: minimum cycles between gate_clk pulses (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  per-requester request level; hold high until done
- din  in  2  per-requester operand; 1 means an input pulse is sent
- gnt  out  2  one-hot, one-cycle grant pulse
- done  out  2  one-hot, one-cycle completion pulse
- dout  out  1  result, valid in the done cycle, held until the next done
- gate_in  out  1  toggle line to the cell data input; each edge is one pulse
- gate_clk  out  1  toggle line to the cell clock input
- gate_out  in  1  toggle line from the cell output; synchronous to clk
- err  out  1  sticky protocol error
- fault  out  1  sticky logic fault, set when dout != !din

## Operation
- States: IDLE, SETUP, WAIT_OUT.
- Counters: cnt is 8 bits. since_clk is 8 bits and saturates at 255.

IDLE:
- Grant is eligible when req != 0 and since_clk >= CT_IN_CYC.
- Round-robin pointer lp: if both requesters are eligible, grant !lp. Otherwise grant the single requester.
- At the grant edge:
  - gnt[g]=1.
  - Latch d=din[g] and lp=g.
  - Toggle gate_in if d=1.
  - cnt=SETUP_CYC-1.
  - Go to SETUP.

SETUP:
- When cnt==0 and since_clk >= CT_CLK_CYC: toggle gate_clk, since_clk=0, cnt=DLY_CYC-1, seen=0, go to WAIT_OUT.
- Otherwise decrement cnt, saturating at 0.

WAIT_OUT:
- A gate_out edge sets seen. A second edge sets err.
- When cnt==0:
  - dout=seen, done[g]=1, go to IDLE.
  - Set fault if seen == d.
- Otherwise decrement cnt.

Edge detection and error rules:
- gate_out edge is gate_out != gate_out_q, using a single flop.
- An edge in IDLE or SETUP sets err.
- req is ignored for the granted requester between gnt and done.
- A requester still high after done is re-arbitrated. lp gives the other requester priority.
- err and fault clear only on rst.

Reset (any time, including mid-transaction):
- All outputs go to 0, including the gate_in and gate_clk levels.
- State goes to IDLE, lp=1 so requester 0 wins first, since_clk=255, gate_out_q=gate_out.
- No done is issued for an aborted transaction.

## Timing
Let the grant occur at edge k.
- gnt is high in the cycle after edge k. gate_in toggles at edge k when d=1.
- gate_clk toggles at edge max(k+SETUP_CYC, k_prevclk+CT_CLK_CYC).
- done and dout update at edge k_clk+DLY_CYC. An edge detected on that edge is counted.
- The next grant occurs at the earliest edge at or after done+1 that also satisfies since_clk >= CT_IN_CYC.
- With the defaults, back-to-back operations are 12 cycles apart.
- Simultaneous req[0] and req[1]:
  - Exactly one is granted; the other waits a full transaction.
  - Grants alternate while both are held.

## Test plan
- **Single operation:** rst, then req=01, din=00, cell toggles gate_out 9 cycles after gate_clk. Required: gnt=01 at k, no gate_in edge, gate_clk edge at k+1, done=01 with dout=1 at k+11, err=0, fault=0.
- **Input pulse:** req=10, din=10, no gate_out edge. Required: gate_in toggles at k, done=10 with dout=0, fault=0.
- **Contention:** req=11 held for four transactions. Required: gnt sequence 01,10,01,10, each 12 cycles apart.
- **CT_CLK enforcement:** DLY_CYC=3, back-to-back requests. Required: second gate_clk exactly 8 cycles after the first (edge k+9), not at k+6.
- **Errors:** an unsolicited gate_out edge in IDLE sets err. A double edge in WAIT_OUT sets err. A gate_out edge with din=1 gives dout=1 and sets fault. Both flags stay set until rst.
- **Reset mid-op:** assert rst during SETUP. Required: all outputs 0 immediately, no done. A new req afterwards is granted normally without holdoff.
